// File: rtl/pwm_sequencer.sv
// pwm_sequencer
//   Drives a PWM waveform from an external free-running WIDTH-bit counter.
//   A start command phase-aligns the counter (one SYNC cycle with clear),
//   then RUN compares the counter value against the active duty. Duty/stop
//   commands arriving in RUN are held in a one-deep pending slot and applied
//   only on a period boundary (counter full), so the waveform never glitches.
//
// Ports
//   clk, reset               rising-edge clock, synchronous active-high reset
//   io_cmd_valid/ready       command handshake
//   io_cmd_payload_duty      high-cycle count, 0..2^WIDTH (larger saturates)
//   io_cmd_payload_stop      1 = stop at the next boundary, duty ignored
//   io_counterValue/Full     from the counter
//   io_counterClear          to the counter, high only in SYNC
//   io_pwm                   PWM output, combinational from counter value
//   io_periodDone            registered pulse after each RUN boundary
//   io_periods               completed-period count (wraps)
//   io_running               high in SYNC or RUN
module pwm_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_cmd_valid,
  output logic             io_cmd_ready,
  input  logic [WIDTH:0]   io_cmd_payload_duty,
  input  logic             io_cmd_payload_stop,
  input  logic [WIDTH-1:0] io_counterValue,
  input  logic             io_counterFull,
  output logic             io_counterClear,
  output logic             io_pwm,
  output logic             io_periodDone,
  output logic [7:0]       io_periods,
  output logic             io_running
);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_RUN} state_e;

  state_e         state_q, state_d;
  logic [WIDTH:0] active_duty_q, active_duty_d;
  logic [WIDTH:0] pend_duty_q, pend_duty_d;
  logic           pend_stop_q, pend_stop_d;
  logic           pend_valid_q, pend_valid_d;
  logic           period_done_q, period_done_d;
  logic [7:0]     periods_q, periods_d;

  logic accept;

  always_comb begin
    case (state_q)
      S_IDLE:  io_cmd_ready = 1'b1;
      S_RUN:   io_cmd_ready = !pend_valid_q;
      default: io_cmd_ready = 1'b0;
    endcase
  end

  assign accept = io_cmd_valid && io_cmd_ready;

  always_comb begin
    state_d       = state_q;
    active_duty_d = active_duty_q;
    pend_duty_d   = pend_duty_q;
    pend_stop_d   = pend_stop_q;
    pend_valid_d  = pend_valid_q;
    period_done_d = 1'b0;
    periods_d     = periods_q;

    case (state_q)
      S_IDLE: begin
        // Stop commands in IDLE are consumed and dropped.
        if (accept && !io_cmd_payload_stop) begin
          active_duty_d = io_cmd_payload_duty;
          periods_d     = 8'd0;
          state_d       = S_SYNC;
        end
      end
      S_SYNC: state_d = S_RUN;
      S_RUN: begin
        if (io_counterFull) begin
          period_done_d = 1'b1;
          periods_d     = periods_q + 8'd1;
          if (pend_valid_q) begin
            if (pend_stop_q) state_d = S_IDLE;
            else             active_duty_d = pend_duty_q;
          end
          pend_valid_d = 1'b0;
        end
        // accept implies the slot was empty, so it cannot collide with the
        // boundary consumption above; a boundary-cycle command waits a period.
        if (accept) begin
          pend_duty_d  = io_cmd_payload_duty;
          pend_stop_d  = io_cmd_payload_stop;
          pend_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      active_duty_q <= '0;
      pend_duty_q   <= '0;
      pend_stop_q   <= 1'b0;
      pend_valid_q  <= 1'b0;
      period_done_q <= 1'b0;
      periods_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      active_duty_q <= active_duty_d;
      pend_duty_q   <= pend_duty_d;
      pend_stop_q   <= pend_stop_d;
      pend_valid_q  <= pend_valid_d;
      period_done_q <= period_done_d;
      periods_q     <= periods_d;
    end
  end

  assign io_counterClear = (state_q == S_SYNC);
  // Unsigned WIDTH+1-bit compare: duty 0 never high, duty >= 2^WIDTH always high.
  assign io_pwm          = (state_q == S_RUN) && ({1'b0, io_counterValue} < active_duty_q);
  assign io_periodDone   = period_done_q;
  assign io_periods      = periods_q;
  assign io_running      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pwm_sequencer.sv
// Bench for pwm_sequencer with a behavioural free-running 4-bit counter.
// Stimulus pushes one expected record per period (pwm pattern by counter
// value, period count, running flag); a monitor rebuilds the observed pattern
// and pops/compares on every io_periodDone pulse.
module tb_pwm_sequencer;
  localparam int WIDTH = 4;

  logic             clk, reset;
  logic             cmd_valid, cmd_ready, cmd_stop;
  logic [WIDTH:0]   cmd_duty;
  logic [WIDTH-1:0] cnt;
  logic             full, clear, pwm, done, running;
  logic [7:0]       periods;

  pwm_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .io_cmd_valid(cmd_valid), .io_cmd_ready(cmd_ready),
    .io_cmd_payload_duty(cmd_duty), .io_cmd_payload_stop(cmd_stop),
    .io_counterValue(cnt), .io_counterFull(full), .io_counterClear(clear),
    .io_pwm(pwm), .io_periodDone(done), .io_periods(periods), .io_running(running)
  );

  // counter model
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else                cnt <= cnt + 4'd1;
  end
  assign full = (cnt == 4'hF);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0] mask;
    logic [7:0]  periods;
    logic        running;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [15:0] pat;
    exp_t e;
    pat = '0;
    forever begin
      @(negedge clk);
      if (reset || clear) pat = '0;
      else begin
        if (done) begin
          if (sb.size() == 0) check("unexpected_period_done", 1, 0);
          else begin
            e = sb.pop_front();
            check("period_pwm_pattern", int'(pat), int'(e.mask));
            check("period_count", int'(periods), int'(e.periods));
            check("running_at_done", int'(running), int'(e.running));
          end
          pat = '0;
        end
        if (running) pat[cnt] = pwm;
      end
    end
  end

  task automatic push(input logic [15:0] m, input logic [7:0] p, input logic r);
    exp_t e;
    e.mask = m; e.periods = p; e.running = r;
    sb.push_back(e);
  endtask

  // All tasks are entered and left at a negedge.
  task automatic send(input logic [WIDTH:0] d, input logic s);
    cmd_valid = 1'b1; cmd_duty = d; cmd_stop = s;
    for (int n = 0; n < 100; n++) begin
      if (cmd_ready) begin
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("send_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cnt(input logic [WIDTH-1:0] v);
    for (int n = 0; n < 64; n++) begin
      if (cnt == v) return;
      @(negedge clk);
    end
    check("wait_cnt_timeout", 0, 1);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (done) return;
    end
    check("wait_done_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    reset = 1'b1; cmd_valid = 1'b0; cmd_duty = '0; cmd_stop = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // reset state
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_pwm", int'(pwm), 0);
    check("rst_clear", int'(clear), 0);
    check("rst_done", int'(done), 0);
    check("rst_periods", int'(periods), 0);
    check("rst_running", int'(running), 0);

    // Reset and start: duty 5, accepted at cycle 0
    push(16'h001F, 8'd1, 1'b1);
    send(5'd5, 1'b0);
    check("sync_clear", int'(clear), 1);               // cycle 1
    check("sync_ready", int'(cmd_ready), 0);
    check("sync_running", int'(running), 1);
    @(negedge clk);                                     // cycle 2
    check("run_clear_low", int'(clear), 0);
    check("run_first_pwm", int'(pwm), 1);
    check("run_first_cnt", int'(cnt), 0);
    bad = 0;
    for (int c = 3; c <= 17; c++) begin
      @(negedge clk);
      if (done || clear) bad++;
    end
    check("no_done_or_clear_c3_17", bad, 0);
    @(negedge clk);                                     // cycle 18
    check("first_done_c18", int'(done), 1);
    check("first_periods", int'(periods), 1);

    // Duty extremes: P2 still 5, P3 duty 0, P4 duty 16, P5 duty 20
    push(16'h001F, 8'd2, 1'b1);
    wait_cnt(4'd3); send(5'd0, 1'b0);
    push(16'h0000, 8'd3, 1'b1);
    wait_done();
    wait_cnt(4'd3); send(5'd16, 1'b0);
    push(16'hFFFF, 8'd4, 1'b1);
    wait_done();
    wait_cnt(4'd3); send(5'd20, 1'b0);
    push(16'hFFFF, 8'd5, 1'b1);
    wait_done();

    // Double buffering: P6 duty 4, 10 pending mid-P6, duty 1 held valid
    wait_cnt(4'd3); send(5'd4, 1'b0);
    push(16'h000F, 8'd6, 1'b1);
    wait_done();
    wait_cnt(4'd2); send(5'd10, 1'b0);
    push(16'h03FF, 8'd7, 1'b1);
    cmd_valid = 1'b1; cmd_duty = 5'd1; cmd_stop = 1'b0;
    bad = 0;
    for (int n = 0; n < 32 && cnt != 4'hF; n++) begin
      if (cmd_ready) bad++;
      @(negedge clk);
    end
    check("ready_low_while_pending", bad, 0);
    check("ready_low_at_boundary", int'(cmd_ready), 0);
    @(negedge clk);
    check("ready_back_after_boundary", int'(cmd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    push(16'h0001, 8'd8, 1'b1);

    // Simultaneous: command accepted on the P8 boundary -> P9 old duty, P10 new
    wait_done();
    wait_cnt(4'hF);
    push(16'h0001, 8'd9, 1'b1);
    push(16'h007F, 8'd10, 1'b0);   // a stop is issued during P10
    send(5'd7, 1'b0);
    check("ready_low_after_boundary_accept", int'(cmd_ready), 0);
    wait_done();

    // Stop mid-period
    wait_cnt(4'd4); send(5'd0, 1'b1);
    wait_done();
    check("stop_running", int'(running), 0);
    check("stop_pwm", int'(pwm), 0);
    check("stop_ready", int'(cmd_ready), 1);
    check("stop_periods", int'(periods), 10);
    // Stop while idle is consumed with no effect
    send(5'd9, 1'b1);
    check("idle_stop_running", int'(running), 0);
    check("idle_stop_clear", int'(clear), 0);
    check("idle_stop_periods", int'(periods), 10);

    // Reset mid-RUN at counter value 7
    send(5'd3, 1'b0);
    @(negedge clk);
    wait_cnt(4'd7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_pwm", int'(pwm), 0);
    check("midrst_periods", int'(periods), 0);
    check("midrst_ready", int'(cmd_ready), 1);
    check("midrst_running", int'(running), 0);
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (clear || running || done) bad++;
    end
    check("midrst_quiet", bad, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pwm_sequencer.md
# pwm_sequencer

Downstream consumer and controller of the free-running 4-bit counter block: turns its `value`/`full` outputs into a PWM waveform and drives its `clear` input to phase-align periods on start. Duty and stop commands arrive on a valid/ready stream. Duty updates are double-buffered and take effect only on a period boundary, so the output is glitch-free.

## Interface
- `WIDTH`, default 4: counter width. The period is 2^WIDTH cycles.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_cmd_valid`  in  1  command valid.
- `io_cmd_ready`  out  1  command ready.
- `io_cmd_payload_duty`  in  WIDTH+1  requested high-cycle count, 0..2^WIDTH.
- `io_cmd_payload_stop`  in  1  1 = stop request; duty is ignored.
- `io_counterValue`  in  WIDTH  from the counter's `io_value`.
- `io_counterFull`  in  1  from the counter's `io_full`.
- `io_counterClear`  out  1  to the counter's `io_clear`.
- `io_pwm`  out  1  PWM output.
- `io_periodDone`  out  1  one-cycle pulse per completed period.
- `io_periods`  out  8  completed-period count, wraps 255→0.
- `io_running`  out  1  high in SYNC or RUN.

## Operation
- A command is accepted on a cycle where `io_cmd_valid && io_cmd_ready`.
- States are IDLE, SYNC and RUN. Reset enters IDLE.
- **IDLE**
  - `io_cmd_ready`=1.
  - An accepted start command (stop=0) loads `active_duty` from the payload, clears `io_periods` to 0 and goes to SYNC.
  - An accepted stop command is consumed with no effect.
- **SYNC**
  - Lasts exactly one cycle, with `io_counterClear`=1 and `io_cmd_ready`=0.
  - Always goes to RUN.
- **RUN**
  - `io_cmd_ready` = !pending_valid.
  - An accepted command is stored in the pending registers (duty, stop) and sets pending_valid.
  - Period boundary: any RUN cycle with `io_counterFull`=1.
    - If pending_valid and stop: go to IDLE.
    - If pending_valid and not stop: `active_duty` ← pending duty.
    - pending_valid is cleared in both cases.
  - A command accepted on the same cycle as a boundary is not applied at that boundary; it is applied at the next one.
- **io_counterClear** = (state==SYNC). It is combinational from state and never asserted outside SYNC.
- **io_pwm** = (state==RUN) && ({1'b0, io_counterValue} < active_duty).
  - Combinational, with zero latency from `io_counterValue`.
  - The compare is unsigned at WIDTH+1 bits.
  - Duty 0 gives always low. Duty ≥ 2^WIDTH gives always high; values above 2^WIDTH saturate to always high.
- **io_periodDone** is a registered pulse: high the cycle after a RUN boundary, including the boundary that causes a stop.
- **io_periods** increments together with `io_periodDone`.
- **io_running** = (state != IDLE).

## Timing
- Reset values:
  - State IDLE.
  - `active_duty` 0; pending cleared.
  - `io_pwm` 0, `io_counterClear` 0, `io_periodDone` 0, `io_periods` 0, `io_running` 0.
  - `io_cmd_ready` 1.
- Reset mid-RUN: the cycle after reset is in IDLE with `io_pwm`=0. Pending and active commands are discarded.
- Start latency, with the start accepted at cycle t:
  - t+1: SYNC, `io_counterClear`=1.
  - t+2: RUN with counter value 0; `io_pwm` valid from this cycle.
  - First `io_periodDone` at t+2+2^WIDTH.
- Duty change: the new duty applies from the first cycle after the boundary, i.e. at counter value 0.
- Stop:
  - Boundary at cycle b means IDLE at b+1.
  - `io_pwm` is low from b+1.
  - `io_periodDone`=1 at b+1.
- Backpressure: in RUN, at most one command is pending. `io_cmd_ready` returns to 1 the cycle after the boundary that consumes it.
- The payload must be held stable while valid && !ready.

## Test plan
- **Reset and start:** reset, then a start with duty=5 accepted at cycle 0.
  - `io_counterClear` high only at cycle 1.
  - `io_pwm` high for 5 cycles from cycle 2, then low for 11.
  - `io_periodDone` pulses at cycle 18; `io_periods`=1.
- **Duty extremes:** run duty=0 for one period, then duty=16, then duty=20.
  - `io_pwm` is all-low for the full duty=0 period.
  - `io_pwm` is all-high for the full duty=16 period and for the full duty=20 period.
- **Double buffering:** duty=4 running; duty=10 accepted mid-period; a second command is held valid.
  - The current period stays at 4 high cycles; the next period has 10.
  - `io_cmd_ready`=0 until the cycle after the boundary.
- **Simultaneous events:** a command is accepted on the exact `io_counterFull` cycle.
  - The next period still uses the old duty.
  - The new duty takes effect one period later.
- **Stop:** stop accepted mid-period.
  - `io_pwm` completes the period.
  - IDLE at boundary+1, with `io_running`=0 and `io_periodDone`=1.
  - A subsequent stop in IDLE is accepted with no effect.
- **Reset mid-RUN:** assert `reset` for 1 cycle at counter value 7.
  - Next cycle: `io_pwm`=0, `io_periods`=0, `io_cmd_ready`=1.
  - No `io_counterClear` until a new start.
